mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Load/store front end sitting directly upstream of the word-wide data memory.
- Accepts one execute-stage memory request at a time and presents a word-aligned address and word write-data to memory.
- Does read-modify-write for sub-word stores, and lane extraction with sign/zero extension for loads.
- Returns one result per request to the writeback side over a valid/ready handshake.

Parameters:
- XLEN, 32, data word width in bits.
- ADDRESSLEN, 32, byte-address width in bits.
- TAM, 16, data memory depth in words; used only by the optional bound check.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
- req_addr  input  ADDRESSLEN  byte address.
- req_wdata  input  XLEN  store data, right-aligned.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts response.
- resp_rdata  output  XLEN  load result after extension; 0 for stores and errors.
- resp_error  output  1  request was rejected (misaligned, illegal funct3, or out of bounds).
- mem_address  output  ADDRESSLEN  byte address to memory; bits [1:0] are forced to 0.
- mem_data  output  XLEN  full word to write.
- mem_iWrite  output  1  memory write enable, sampled by memory on the rising edge.
- mem_out  input  XLEN  memory read word; memory updates it on the falling edge from mem_address.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, port name reset.
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_error=0; mem_address=0; mem_data=0; mem_iWrite=0.
- All outputs come from registers or decode of the state register. No combinational path from any input to any output.
- States:
  - IDLE: req_ready=1. Accept on a clk edge with req_valid=1. On accept, register addr, funct3, write and wdata, then:
    - error detected -> RESP;
    - load or SB/SH -> READ;
    - SW -> WRITE.
  - READ: one cycle. mem_address = {addr[ADDRESSLEN-1:2], 2'b00}; memory presents mem_out at the falling edge. At the end-of-cycle edge, capture mem_out. A load goes to RESP. A sub-word store builds the merged word and goes to WRITE.
  - WRITE: one cycle, mem_iWrite=1.
    - mem_data = wdata for SW.
    - For SB, byte lane addr[1:0] of the captured word is replaced by wdata[7:0].
    - For SH, half lane addr[1] is replaced by wdata[15:0].
    - Next state RESP.
  - RESP: resp_valid=1 and result held stable until an edge with resp_ready=1, then IDLE. req_ready=0 in every state except IDLE.
- Load extraction:
  - The byte at addr[1:0] is taken from bits [8*addr[1:0]+7 : 8*addr[1:0]]; the half at addr[1].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word unchanged.
- Errors (no memory access, mem_iWrite never asserted, resp_error=1, resp_rdata=0):
  - LH, LHU or SH with addr[0]=1.
  - LW or SW with addr[1:0]!=0.
  - Load funct3 in {011, 110, 111}; store funct3 with bit 2 set or equal to 011.
- Latency, from accept edge to first resp_valid cycle, with resp_ready held high:
  - Load: 2 edges.
  - SW: 2 edges.
  - SB/SH: 3 edges.
  - Error: 1 edge.
- Throughput: one request in flight at a time. A new accept is possible at the edge after the response handshake.
- Reset mid-operation: returns to IDLE immediately and mem_iWrite drops asynchronously. A store interrupted in READ never writes. A store in WRITE when reset asserts before the edge does not write.
- mem_address keeps its last value in IDLE; memory reads are side-effect free.

Optional Feature:
- Macro: MEM_ACCESS_BOUND_CHECK_EN.
- Defined: a request with addr[ADDRESSLEN-1:2] >= TAM is an error, handled like a misaligned request (no access, resp_error=1, rdata=0).
- Undefined: no range check; the word index is passed through unchecked.

Test Plan:
- SW addr 0x08 data 0xDEADBEEF, then LW 0x08 -> mem_iWrite high exactly one cycle; resp_rdata=0xDEADBEEF, resp_error=0; response 2 edges after accept.
- After the above, LB 0x09 -> 0xFFFFFFBE; LBU 0x0B -> 0x000000DE; LHU 0x0A -> 0x0000DEAD; LH 0x08 -> 0xFFFFBEEF.
- SB 0x0A data 0x00000011, then LW 0x08 -> 0xDE11BEEF; store response 3 edges after accept; single mem_iWrite pulse with mem_data=0xDE11BEEF.
- LW 0x06, SH 0x05, and load funct3=011 -> each gives resp_error=1, resp_rdata=0, no mem_iWrite, response 1 edge after accept.
- Hold resp_ready=0 for 4 cycles after a LW -> resp_valid and data stable, req_ready=0, a second req_valid is not accepted; accepted after the handshake.
- Assert reset during READ of SB 0x08 data 0x55 -> outputs at reset values immediately, no write, LW 0x08 returns the prior word. With MEM_ACCESS_BOUND_CHECK_EN and TAM=16, LW 0x40 -> resp_error=1.

Source files
------------

// File: rtl/mem_access_if.sv
// mem_access_if: request/response channel between the execute/writeback
// side and the load/store unit.
//   req_*  : one memory request (valid/ready), byte address, funct3, store data
//   resp_* : one result per request (valid/ready), extended load data, error flag
// Modports: master = requester (execute/writeback side), slave = mem_access_unit.
interface mem_access_if #(
   parameter int XLEN       = 32,
   parameter int ADDRESSLEN = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [2:0]            req_funct3;
   logic [ADDRESSLEN-1:0] req_addr;
   logic [XLEN-1:0]       req_wdata;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [XLEN-1:0]       resp_rdata;
   logic                  resp_error;

   modport master (
      output req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_error
   );

   modport slave (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_error
   );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front end in front of a word-wide data memory.
// Takes one request at a time, does read-modify-write for SB/SH, lane
// extraction with sign/zero extension for loads, and returns one response.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high
//   bus         mem_access_if.slave request/response channel
//   mem_address word-aligned byte address to memory (bits [1:0] = 0)
//   mem_data    full word to write
//   mem_iWrite  write enable, sampled by memory on the rising edge
//   mem_out     read word, updated by memory on the falling edge
//
// Build option: define MEM_ACCESS_BOUND_CHECK_EN to reject requests whose
// word index is >= TAM.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a request; mem_address holds its last value
// READ   | memory word read; load extracted or sub-word store merged
// WRITE  | mem_iWrite high for exactly this cycle
// RESP   | response presented until resp_ready
module mem_access_unit #(
   parameter int XLEN       = 32,
   parameter int ADDRESSLEN = 32,
   parameter int TAM        = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   mem_access_if.slave           bus,
   output logic [ADDRESSLEN-1:0] mem_address,
   output logic [XLEN-1:0]       mem_data,
   output logic                  mem_iWrite,
   input  logic [XLEN-1:0]       mem_out
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam logic [ADDRESSLEN-3:0] L_TAM = (ADDRESSLEN-2)'(TAM);

   state_t                r_state;
   state_t                w_next_state;

   logic [1:0]            r_lane;
   logic [2:0]            r_funct3;
   logic                  r_write;
   logic [15:0]           r_wdata_lo;
   logic [XLEN-1:0]       r_rdata;
   logic                  r_error;
   logic [ADDRESSLEN-1:0] r_mem_address;
   logic [XLEN-1:0]       r_mem_data;

   logic                  w_accept;
   logic                  w_f3_bad;
   logic                  w_misalign;
   logic                  w_oob;
   logic                  w_req_err;
   logic                  w_is_sw;
   logic [7:0]            w_byte;
   logic [15:0]           w_half;
   logic [XLEN-1:0]       w_load_data;
   logic [XLEN-1:0]       w_merged;

   // ---------------------------------------------------------------
   // Request decode
   // ---------------------------------------------------------------
`ifdef MEM_ACCESS_BOUND_CHECK_EN
   assign w_oob = (bus.req_addr[ADDRESSLEN-1:2] >= L_TAM);
`else
   // Word index passes through unchecked; the range limit is inert here.
   logic w_unused_tam;
   assign w_unused_tam = ^L_TAM;
   assign w_oob        = 1'b0;
`endif

   always_comb begin
      w_f3_bad   = 1'b0;
      w_misalign = 1'b0;
      if (bus.req_write) begin
         w_f3_bad = bus.req_funct3[2] || (bus.req_funct3 == 3'b011);
      end else begin
         w_f3_bad = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                    (bus.req_funct3 == 3'b111);
      end
      // Size field funct3[1:0]: 01 = half, 10 = word. Illegal codes are
      // already caught above, so no need to qualify with funct3[2].
      if ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) begin
         w_misalign = 1'b1;
      end
      if ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00)) begin
         w_misalign = 1'b1;
      end
   end

   assign w_req_err = w_f3_bad || w_misalign || w_oob;
   assign w_is_sw   = bus.req_write && (bus.req_funct3 == 3'b010);
   assign w_accept  = (r_state == ST_IDLE) && bus.req_valid;

   // ---------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (bus.req_valid) begin
               if (w_req_err) begin
                  w_next_state = ST_RESP;
               end else if (w_is_sw) begin
                  w_next_state = ST_WRITE;
               end else begin
                  w_next_state = ST_READ;
               end
            end
         end
         ST_READ: begin
            w_next_state = r_write ? ST_WRITE : ST_RESP;
         end
         ST_WRITE: begin
            w_next_state = ST_RESP;
         end
         ST_RESP: begin
            if (bus.resp_ready) begin
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Lane extraction and sub-word merge from the memory word
   // ---------------------------------------------------------------
   assign w_byte = mem_out[{r_lane, 3'b000} +: 8];
   assign w_half = mem_out[{r_lane[1], 4'b0000} +: 16];

   always_comb begin
      w_load_data = mem_out;
      case (r_funct3[1:0])
         2'b00:   w_load_data = {{(XLEN-8){w_byte[7] & ~r_funct3[2]}}, w_byte};
         2'b01:   w_load_data = {{(XLEN-16){w_half[15] & ~r_funct3[2]}}, w_half};
         default: w_load_data = mem_out;
      endcase
   end

   always_comb begin
      w_merged = mem_out;
      if (r_funct3[1:0] == 2'b00) begin
         w_merged[{r_lane, 3'b000} +: 8] = r_wdata_lo[7:0];
      end else begin
         w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata_lo;
      end
   end

   // ---------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lane        <= 2'b00;
         r_funct3      <= 3'b000;
         r_write       <= 1'b0;
         r_wdata_lo    <= '0;
         r_rdata       <= '0;
         r_error       <= 1'b0;
         r_mem_address <= '0;
         r_mem_data    <= '0;
      end else begin
         if (w_accept) begin
            r_lane     <= bus.req_addr[1:0];
            r_funct3   <= bus.req_funct3;
            r_write    <= bus.req_write;
            r_wdata_lo <= bus.req_wdata[15:0];
            r_rdata    <= '0;
            r_error    <= w_req_err;
            // Rejected requests leave the memory-side registers untouched.
            if (!w_req_err) begin
               r_mem_address <= {bus.req_addr[ADDRESSLEN-1:2], 2'b00};
               if (w_is_sw) begin
                  r_mem_data <= bus.req_wdata;
               end
            end
         end
         if (r_state == ST_READ) begin
            if (r_write) begin
               r_mem_data <= w_merged;
            end else begin
               r_rdata <= w_load_data;
            end
         end
      end
   end

   // ---------------------------------------------------------------
   // Outputs: registers or state decode only
   // ---------------------------------------------------------------
   assign mem_address    = r_mem_address;
   assign mem_data       = r_mem_data;
   assign mem_iWrite     = (r_state == ST_WRITE);
   assign bus.req_ready  = (r_state == ST_IDLE);
   assign bus.resp_valid = (r_state == ST_RESP);
   assign bus.resp_rdata = r_rdata;
   assign bus.resp_error = r_error;

endmodule
